// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2
    } arb_state_t;

    localparam int DEFAULT_STARVE_LIMIT = 4;

    // Counter must hold values 0..limit inclusive; never narrower than one bit.
    function automatic int starve_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates instruction fetch and data accesses onto one memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [AW-1:0] if_rdata,

    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [AW-1:0] dm_wdata,
    output logic          dm_ready,
    output logic [AW-1:0] dm_rdata,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    input  logic [AW-1:0] mem_rdata,
    input  logic          mem_ready,

    output logic          stall
);

    localparam int            CW      = starve_cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    arb_state_t    state;
    logic [CW-1:0] starve_cnt;
    logic          dm_win;
    logic          can_grant;

    // Data side wins unless a waiting fetch has already been passed over LIMIT times.
    assign dm_win    = dm_req && ((starve_cnt < LIMIT_C) || !if_req);
    // The ready-pulse cycle is kept idle so a requester still holding req is not re-granted.
    assign can_grant = !if_ready && !dm_ready;

    assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (can_grant) begin
                        if (dm_win) begin
                            state     <= ST_BUSY_DM;
                            mem_req   <= 1'b1;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            if (if_req && (starve_cnt != LIMIT_C)) begin
                                starve_cnt <= starve_cnt + CW'(1);
                            end
                        end else if (if_req) begin
                            state      <= ST_BUSY_IF;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                            starve_cnt <= '0;
                        end
                    end
                end
                ST_BUSY_IF: begin
                    if (mem_ready) begin
                        state    <= ST_IDLE;
                        mem_req  <= 1'b0;
                        if_ready <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                ST_BUSY_DM: begin
                    if (mem_ready) begin
                        state    <= ST_IDLE;
                        mem_req  <= 1'b0;
                        dm_ready <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants allowed while a fetch waits.
REQ-002 Parameter AW, default 32: address/data width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  instruction-fetch request, held until if_ready.
REQ-006 if_addr  in  AW  fetch address (PC).
REQ-007 if_ready  out  1  one-cycle pulse, fetch complete.
REQ-008 if_rdata  out  AW  fetched instruction, held until next fetch completes.
REQ-009 dm_req  in  1  data-memory request, held until dm_ready.
REQ-010 dm_we  in  1  1 = write, 0 = read.
REQ-011 dm_addr  in  AW  data address.
REQ-012 dm_wdata  in  AW  store data.
REQ-013 dm_ready  out  1  one-cycle pulse, data access complete.
REQ-014 dm_rdata  out  AW  load data, held until next data read completes.
REQ-015 mem_req  out  1  request to the single shared memory port.
REQ-016 mem_we / mem_addr / mem_wdata  out  1/AW/AW  registered command to memory.
REQ-017 mem_rdata  in  AW  memory read data, valid with mem_ready.
REQ-018 mem_ready  in  1  memory completion pulse, variable latency >= 1 cycle.
REQ-019 stall  out  1  pipeline stall = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational.

Function
REQ-020 FSM states IDLE, BUSY_IF, BUSY_DM; exactly one transaction outstanding at a time.
REQ-021 IDLE -> BUSY_DM when dm_req and (starve_cnt < STARVE_LIMIT or ~if_req).
REQ-022 IDLE -> BUSY_IF when if_req and the REQ-021 condition is false.
REQ-023 Grant decision made in cycle N; mem_req, mem_addr, mem_we, mem_wdata registered and asserted from cycle N+1.
REQ-024 mem_req and the command stay constant in BUSY_* until mem_ready is sampled high.
REQ-025 On mem_ready in BUSY_X: X_ready pulses the next cycle; for reads, X_rdata captures mem_rdata; FSM returns to IDLE.
REQ-026 One IDLE cycle after every completion; minimum request-to-ready latency is 3 cycles with 1-cycle memory.
REQ-027 mem_we forced 0 for fetch grants; dm_rdata not updated on data writes.
REQ-028 starve_cnt increments (saturating at STARVE_LIMIT) on each DM grant made while if_req is high; clears on every IF grant.
REQ-029 mem_ready while IDLE is ignored; no ready pulse, no rdata update.
REQ-030 Requester dropping req mid-transaction: transaction still completes and ready still pulses.
REQ-031 Simultaneous if_req and dm_req in IDLE: DM wins unless starve_cnt = STARVE_LIMIT.
REQ-032 Inputs sampled only at grant; address changes during BUSY_* have no effect.

Reset
REQ-033 On rst: state IDLE, starve_cnt 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, if_ready 0, dm_ready 0, if_rdata 0, dm_rdata 0.
REQ-034 Reset mid-transaction abandons it: no ready pulse is issued, and a mem_ready arriving after reset is ignored per REQ-029.
REQ-035 rst has priority over every other input in the same cycle.

Structure
REQ-036 Shared package holds the FSM state encoding (2 bits) and default STARVE_LIMIT constant.
REQ-037 Single module; starve counter and grant logic inline, no sub-modules.

Verification
REQ-038 Fetch only, 1-cycle memory: if_req=1, if_addr=0x4, mem_rdata=0x20080005 -> mem_req high at cycle 1, if_ready pulse at cycle 3, if_rdata=0x20080005, stall low in cycle 3.
REQ-039 Simultaneous requests: if_addr=0x8, dm_req read dm_addr=0x100 -> mem_addr=0x100 first, dm_ready first, then mem_addr=0x8 and if_ready.
REQ-040 Starvation: dm_req held high with repeated transactions, if_req held, STARVE_LIMIT=4 -> exactly 4 DM grants, then IF grant, starve_cnt back to 0.
REQ-041 Write: dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF, 3-cycle memory -> mem_we=1 held 3 cycles, dm_ready pulse, dm_rdata unchanged.
REQ-042 Reset during BUSY_DM with memory latency 5: assert rst at cycle 2 -> mem_req 0 next cycle, no dm_ready, late mem_ready ignored.
REQ-043 Spurious mem_ready in IDLE -> no ready pulses, rdata registers unchanged.
